// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared state encoding and counter helpers for the cache read controller
package cache_ctrl_pkg;

  localparam int CNT_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    COMPARE   = 3'd2,
    FETCH     = 3'd3,
    MISS_REQ  = 3'd4,
    MISS_WAIT = 3'd5,
    FILL      = 3'd6,
    RESP      = 3'd7
  } state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/cache_read_controller_onehot_check.sv
// rtl/cache_read_controller_onehot_check.sv - classifies a way vector as empty, one-hot or multi-bit
module onehot_check #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic             isZero,
  output logic             isOneHot,
  output logic             isMulti
);

  logic [WIDTH-1:0] w_dec;

  // v & (v-1) clears the lowest set bit; nothing left means at most one bit was set.
  assign w_dec    = i_vec - WIDTH'(1);
  assign isZero   = ~|i_vec;
  assign isOneHot = !isZero && ~|(i_vec & w_dec);
  assign isMulti  = !isZero && !isOneHot;

endmodule

// File: rtl/cache_read_controller.sv
// rtl/cache_read_controller.sv - one-at-a-time CPU read sequencer: tag lookup, way fetch, miss fill
module cache_read_controller
  import cache_ctrl_pkg::*;
#(
  parameter int NUM_WAYS   = 512,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpuReqValid,
  output logic                  cpuReqReady,
  input  logic [ADDR_WIDTH-1:0] cpuReqAddr,
  output logic                  cpuRespValid,
  input  logic                  cpuRespReady,
  output logic [DATA_WIDTH-1:0] cpuRespData,
  output logic                  cpuRespErr,
  output logic                  lookupValid,
  output logic [ADDR_WIDTH-1:0] lookupAddr,
  input  logic [NUM_WAYS-1:0]   hitVec,
  input  logic [NUM_WAYS-1:0]   victimWay,
  output logic [NUM_WAYS-1:0]   targetWay,
  input  logic [DATA_WIDTH-1:0] fetchedData,
  output logic                  memReqValid,
  input  logic                  memReqReady,
  output logic [ADDR_WIDTH-1:0] memReqAddr,
  input  logic                  memRespValid,
  input  logic [DATA_WIDTH-1:0] memRespData,
  output logic [NUM_WAYS-1:0]   fillWe,
  output logic [DATA_WIDTH-1:0] fillData,
  output logic [CNT_WIDTH-1:0]  hitCount,
  output logic [CNT_WIDTH-1:0]  missCount
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [NUM_WAYS-1:0]   r_victim;
  logic [NUM_WAYS-1:0]   r_target;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_hit_cnt;
  logic [CNT_WIDTH-1:0]  r_miss_cnt;

  logic w_hit_zero, w_hit_one, w_hit_multi;
  logic w_vic_zero, w_vic_one, w_vic_multi;

  onehot_check #(.WIDTH(NUM_WAYS)) u_hit_chk (
    .i_vec    (hitVec),
    .isZero   (w_hit_zero),
    .isOneHot (w_hit_one),
    .isMulti  (w_hit_multi)
  );

  // Checks the latched victim, so a changing victimWay input after the miss decision is harmless.
  onehot_check #(.WIDTH(NUM_WAYS)) u_vic_chk (
    .i_vec    (r_victim),
    .isZero   (w_vic_zero),
    .isOneHot (w_vic_one),
    .isMulti  (w_vic_multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_victim   <= '0;
      r_target   <= '0;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (cpuReqValid) begin
          r_addr  <= cpuReqAddr;
          r_state <= LOOKUP;
        end
        LOOKUP: r_state <= COMPARE;
        COMPARE: begin
          if (w_hit_one) begin
            r_target <= hitVec;
            r_state  <= FETCH;
          end else if (w_hit_zero) begin
            r_victim <= victimWay;
            r_state  <= MISS_REQ;
          end else if (w_hit_multi) begin
            r_err   <= 1'b1;
            r_data  <= '0;
            r_state <= RESP;
          end
        end
        FETCH: begin
          r_data    <= fetchedData;
          r_target  <= '0;
          r_hit_cnt <= sat_inc(r_hit_cnt);
          r_state   <= RESP;
        end
        MISS_REQ: if (memReqReady) begin
          r_miss_cnt <= sat_inc(r_miss_cnt);
          r_state    <= MISS_WAIT;
        end
        MISS_WAIT: if (memRespValid) begin
          r_data  <= memRespData;
          r_state <= FILL;
        end
        FILL: begin
          r_err   <= w_vic_zero | w_vic_multi;
          r_state <= RESP;
        end
        RESP: if (cpuRespReady) begin
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpuReqReady  = (r_state == IDLE);
  assign lookupValid  = (r_state == LOOKUP);
  assign lookupAddr   = r_addr;
  assign targetWay    = r_target;
  assign memReqValid  = (r_state == MISS_REQ);
  assign memReqAddr   = r_addr;
  assign fillWe       = (r_state == FILL && w_vic_one) ? r_victim : '0;
  assign fillData     = r_data;
  assign cpuRespValid = (r_state == RESP);
  assign cpuRespData  = r_data;
  assign cpuRespErr   = r_err;
  assign hitCount     = r_hit_cnt;
  assign missCount    = r_miss_cnt;

endmodule

// File: tb/tb_cache_read_controller.sv
// tb/tb_cache_read_controller.sv - table-driven and randomized self-checking bench for cache_read_controller
module tb_cache_read_controller;

  localparam int NW = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpuReqValid, cpuReqReady;
  logic [31:0]   cpuReqAddr;
  logic          cpuRespValid, cpuRespReady, cpuRespErr;
  logic [31:0]   cpuRespData;
  logic          lookupValid;
  logic [31:0]   lookupAddr;
  logic [NW-1:0] hitVec, victimWay, targetWay, fillWe;
  logic [31:0]   fetchedData;
  logic          memReqValid, memReqReady, memRespValid;
  logic [31:0]   memReqAddr, memRespData, fillData, hitCount, missCount;

  always #5 clk = ~clk;

  cache_read_controller #(.NUM_WAYS(NW), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpuReqValid(cpuReqValid), .cpuReqReady(cpuReqReady), .cpuReqAddr(cpuReqAddr),
    .cpuRespValid(cpuRespValid), .cpuRespReady(cpuRespReady),
    .cpuRespData(cpuRespData), .cpuRespErr(cpuRespErr),
    .lookupValid(lookupValid), .lookupAddr(lookupAddr),
    .hitVec(hitVec), .victimWay(victimWay), .targetWay(targetWay), .fetchedData(fetchedData),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .fillWe(fillWe), .fillData(fillData), .hitCount(hitCount), .missCount(missCount)
  );

  logic [31:0] way_data [NW];

  // Way-data fetcher: combinational read of the selected way.
  always_comb begin
    fetchedData = '0;
    for (int i = 0; i < NW; i++)
      if (targetWay[i]) fetchedData = fetchedData | way_data[i];
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_hits, exp_misses;

  task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] oh(input int i);
    logic [NW-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference: classify by popcount, pick hit data / memory word / error per the read rules.
  function automatic void model_expect(input logic [NW-1:0] hv, input logic [NW-1:0] vic,
                                       input logic [31:0] md, output logic [31:0] e_data,
                                       output logic e_err, output logic [NW-1:0] e_fill);
    int n;
    n = $countones(hv);
    e_data = '0; e_err = 1'b0; e_fill = '0;
    if (n == 1) begin
      for (int i = 0; i < NW; i++) if (hv[i]) e_data = way_data[i];
    end else if (n == 0) begin
      e_data = md;
      if ($countones(vic) == 1) e_fill = vic;
      else e_err = 1'b1;
    end else begin
      e_err = 1'b1;
    end
  endfunction

  logic [31:0]   ob_data, ob_fill_data, ob_mem_addr;
  logic          ob_err;
  logic [NW-1:0] ob_target, ob_fill;
  int            ob_target_cycles, ob_fill_cycles, ob_memreq, ob_lookup, ob_lat;
  bit            ob_stable, ob_timeout;

  task automatic run_txn(input logic [31:0] addr, input logic [NW-1:0] hv, input logic [NW-1:0] vic,
                         input logic [31:0] md, input int mdel, input int rdel);
    int cyc, mw, rw, ret;
    bit hs, done, seen_resp, seen_mem;
    logic [31:0] a0;
    ob_data = '0; ob_err = 1'b0; ob_target = '0; ob_fill = '0; ob_fill_data = '0; ob_mem_addr = '0;
    ob_target_cycles = 0; ob_fill_cycles = 0; ob_memreq = 0; ob_lookup = 0; ob_lat = -1;
    ob_stable = 1'b1; ob_timeout = 1'b0;
    hitVec = hv; victimWay = vic;
    if (!cpuReqReady) ob_stable = 1'b0;
    cpuReqValid = 1'b1; cpuReqAddr = addr;
    @(negedge clk);
    cpuReqValid = 1'b0; cpuReqAddr = $urandom;
    cyc = 1; mw = 0; rw = 0; ret = -1; hs = 0; done = 0; seen_resp = 0; seen_mem = 0; a0 = '0;
    while (!done && cyc < 200) begin
      // A stray memory response during LOOKUP must be ignored.
      memRespValid = (cyc == 1); memRespData = 32'hBAD0_BAD0;
      if (hs) begin
        if (ret == 0) begin memRespValid = 1'b1; memRespData = md; end
        ret--;
      end
      if (cpuReqReady) ob_stable = 1'b0;
      if (lookupValid) begin
        ob_lookup++;
        if (lookupAddr !== addr) ob_stable = 1'b0;
      end
      if (targetWay != '0) begin ob_target |= targetWay; ob_target_cycles++; end
      if (fillWe != '0) begin ob_fill |= fillWe; ob_fill_cycles++; ob_fill_data = fillData; end
      if (seen_mem && !hs && !memReqValid) ob_stable = 1'b0;
      memReqReady = 1'b0;
      if (memReqValid && !hs) begin
        if (!seen_mem) begin seen_mem = 1; a0 = memReqAddr; end
        else if (memReqAddr !== a0) ob_stable = 1'b0;
        ob_mem_addr = memReqAddr;
        if (mw < mdel) mw++;
        else begin memReqReady = 1'b1; hs = 1; ob_memreq++; ret = 1; end
      end else if (memReqValid) begin
        ob_memreq++;
      end
      cpuRespReady = 1'b0;
      if (cpuRespValid) begin
        if (!seen_resp) begin
          seen_resp = 1; ob_lat = cyc; ob_data = cpuRespData; ob_err = cpuRespErr;
        end else if (cpuRespData !== ob_data || cpuRespErr !== ob_err) ob_stable = 1'b0;
        if (rw < rdel) rw++;
        else begin cpuRespReady = 1'b1; done = 1; end
      end
      @(negedge clk);
      cyc++;
    end
    cpuRespReady = 1'b0; memReqReady = 1'b0; memRespValid = 1'b0;
    if (!done) ob_timeout = 1'b1;
  endtask

  task automatic check_txn(input string tag, input logic [31:0] addr, input logic [NW-1:0] hv,
                           input logic [31:0] e_data, input logic e_err, input logic [NW-1:0] e_fill);
    int n;
    n = $countones(hv);
    chk({tag, ".timeout"}, NW'(ob_timeout), '0);
    chk({tag, ".data"}, NW'(ob_data), NW'(e_data));
    chk({tag, ".err"}, NW'(ob_err), NW'(e_err));
    chk({tag, ".fillWe"}, ob_fill, e_fill);
    chk({tag, ".fill_cycles"}, NW'(ob_fill_cycles), NW'((e_fill != '0) ? 1 : 0));
    if (e_fill != '0) chk({tag, ".fillData"}, NW'(ob_fill_data), NW'(e_data));
    chk({tag, ".lookup_cycles"}, NW'(ob_lookup), NW'(1));
    chk({tag, ".targetWay"}, ob_target, (n == 1) ? hv : '0);
    chk({tag, ".target_cycles"}, NW'(ob_target_cycles), NW'((n == 1) ? 1 : 0));
    chk({tag, ".mem_handshakes"}, NW'(ob_memreq), NW'((n == 0) ? 1 : 0));
    if (n == 0) chk({tag, ".memReqAddr"}, NW'(ob_mem_addr), NW'(addr));
    if (n == 1) chk({tag, ".hit_latency"}, NW'(ob_lat), NW'(4));
    chk({tag, ".stable"}, NW'(ob_stable), NW'(1));
    if (n == 1 && exp_hits != 32'hFFFF_FFFF) exp_hits++;
    if (n == 0 && exp_misses != 32'hFFFF_FFFF) exp_misses++;
    chk({tag, ".hitCount"}, NW'(hitCount), NW'(exp_hits));
    chk({tag, ".missCount"}, NW'(missCount), NW'(exp_misses));
    chk({tag, ".back_to_idle"}, NW'({cpuReqReady, cpuRespValid}), NW'(2'b10));
  endtask

  typedef struct {
    string         name;
    logic [NW-1:0] hv;
    logic [NW-1:0] vic;
    logic [31:0]   md;
    int            mdel;
    int            rdel;
    logic [31:0]   e_data;
    logic          e_err;
    logic [NW-1:0] e_fill;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [NW-1:0] hv, vic, e_fill;
    logic [31:0]   md, e_data, addr;
    logic          e_err;
    int            sel, i0, i1, n_junk;

    for (int i = 0; i < NW; i++) way_data[i] = $urandom;
    way_data[3]   = 32'hDEAD_BEEF;
    way_data[511] = 32'hA5A5_01FF;

    tbl[0] = '{"hit_way3",      oh(3),          oh(1),            32'h0,          0, 0, 32'hDEAD_BEEF, 1'b0, '0};
    tbl[1] = '{"miss_way7",     '0,             oh(7),            32'hCAFE_0001,  0, 0, 32'hCAFE_0001, 1'b0, oh(7)};
    tbl[2] = '{"multi_hit",     oh(2) | oh(9),  oh(4),            32'h1111_2222,  0, 0, 32'h0,         1'b1, '0};
    tbl[3] = '{"bp_miss",       '0,             oh(20),           32'h1357_2468,  3, 5, 32'h1357_2468, 1'b0, oh(20)};
    tbl[4] = '{"bp_hit_511",    oh(511),        '0,               32'h0,          0, 5, 32'hA5A5_01FF, 1'b0, '0};
    tbl[5] = '{"victim_zero",   '0,             '0,               32'h1234_5678,  1, 0, 32'h1234_5678, 1'b1, '0};
    tbl[6] = '{"victim_two",    '0,             oh(0) | oh(511),  32'h8765_4321,  0, 1, 32'h8765_4321, 1'b1, '0};

    rst_n = 1'b0;
    cpuReqValid = 0; cpuReqAddr = '0; cpuRespReady = 0; hitVec = '0; victimWay = '0;
    memReqReady = 0; memRespValid = 0; memRespData = '0;
    exp_hits = '0; exp_misses = '0;
    repeat (3) @(negedge clk);
    chk("reset.valids", NW'({cpuRespValid, lookupValid, memReqValid, cpuRespErr}), '0);
    chk("reset.ways", targetWay | fillWe, '0);
    chk("reset.regs", NW'({cpuRespData, memReqAddr, hitCount, missCount}), '0);
    chk("reset.cpuReqReady", NW'(cpuReqReady), NW'(1));
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 7; t++) begin
      addr = 32'h1000_0040 + 32'(t * 4);
      run_txn(addr, tbl[t].hv, tbl[t].vic, tbl[t].md, tbl[t].mdel, tbl[t].rdel);
      check_txn(tbl[t].name, addr, tbl[t].hv, tbl[t].e_data, tbl[t].e_err, tbl[t].e_fill);
    end

    // Reset while waiting for memory data, then a late response must do nothing.
    hitVec = '0; victimWay = oh(5);
    cpuReqValid = 1'b1; cpuReqAddr = 32'h0000_ABC0;
    @(negedge clk);
    cpuReqValid = 1'b0;
    for (int k = 0; k < 20 && !memReqValid; k++) @(negedge clk);
    chk("rst_mid.memReqValid_seen", NW'(memReqValid), NW'(1));
    memReqReady = 1'b1;
    @(negedge clk);
    memReqReady = 1'b0;
    chk("rst_mid.in_wait", NW'(memReqValid), '0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.valids", NW'({cpuRespValid, lookupValid, memReqValid, cpuRespErr}), '0);
    chk("rst_mid.ways", targetWay | fillWe, '0);
    chk("rst_mid.counts", NW'({hitCount, missCount, cpuRespData}), '0);
    chk("rst_mid.idle", NW'(cpuReqReady), NW'(1));
    exp_hits = '0; exp_misses = '0;
    @(negedge clk);
    rst_n = 1'b1;
    memRespValid = 1'b1; memRespData = 32'hFEED_FACE;
    @(negedge clk);
    memRespValid = 1'b0;
    n_junk = 0;
    for (int k = 0; k < 4; k++) begin
      if (fillWe != '0 || cpuRespValid || memReqValid || !cpuReqReady) n_junk++;
      @(negedge clk);
    end
    chk("rst_mid.late_resp_ignored", NW'(n_junk), '0);
    run_txn(32'h0000_ABC4, '0, oh(5), 32'h0BAD_F00D, 0, 0);
    check_txn("after_reset_miss", 32'h0000_ABC4, '0, 32'h0BAD_F00D, 1'b0, oh(5));

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      i0 = $urandom_range(0, NW - 1);
      i1 = (i0 + $urandom_range(1, NW - 1)) % NW;
      if (sel < 6) hv = oh(i0);
      else if (sel < 9) hv = '0;
      else hv = oh(i0) | oh(i1);
      vic = ($urandom_range(0, 7) == 0) ? '0 : oh($urandom_range(0, NW - 1));
      md = $urandom;
      addr = $urandom;
      model_expect(hv, vic, md, e_data, e_err, e_fill);
      run_txn(addr, hv, vic, md, $urandom_range(0, 3), $urandom_range(0, 3));
      check_txn($sformatf("rand%0d", t), addr, hv, e_data, e_err, e_fill);
    end

    // Saturation: preload the hit counter at all-ones, one more hit must not wrap.
    force dut.r_hit_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_hit_cnt;
    @(negedge clk);
    exp_hits = 32'hFFFF_FFFF;
    chk("sat.preload", NW'(hitCount), NW'(32'hFFFF_FFFF));
    run_txn(32'h2000_0000, oh(3), '0, 32'h0, 0, 0);
    check_txn("sat_hit", 32'h2000_0000, oh(3), 32'hDEAD_BEEF, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
